// File: rtl/data_memory.sv
// data_memory: word-addressed RAM with a combinational read port and a
// single-edge synchronous clear.
//   - Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits. Every address is
//     valid; addresses do not wrap or alias.
//   - Writes happen on the rising clk edge and can be read from the next cycle.
//   - The read path has no latency. ReadData is all zeros while MemRead is low.
//   - rst is synchronous and active low. It clears every word in one edge,
//     and it overrides a write requested in the same cycle.
// Optional build macro DATA_MEMORY_FWD_EN:
//   When defined, a simultaneous read and write (with rst high) forwards
//   WriteData straight to ReadData.
//   When undefined, ReadData shows the stored word until the write edge.
module data_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] ReadData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Flop-based array: a RAM macro could not clear all words in one edge.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Next memory contents. Only a write enable of exactly 1 modifies a word.
    always_comb begin
        mem_d = mem_q;
        if (MemWrite == 1'b1) begin
            mem_d[Address] = WriteData;
        end
    end

    // Storage register. Reset clears every word and discards any pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read port, gated to zero when no read is requested.
    always_comb begin
        ReadData = '0;
        if (MemRead == 1'b1) begin
`ifdef DATA_MEMORY_FWD_EN
            if (MemWrite == 1'b1 && rst == 1'b1) begin
                ReadData = WriteData;
            end else begin
                ReadData = mem_q[Address];
            end
`else
            ReadData = mem_q[Address];
`endif
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Testbench for data_memory.
// It runs directed boundary and reset scenarios, then randomized traffic.
// All results are compared against an array model of the memory contents.
module tb_data_memory;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Address;
    logic [DW-1:0] WriteData;
    logic          MemRead;
    logic          MemWrite;
    logic [DW-1:0] ReadData;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: the contents the memory should hold.
    int ref_mem [DEPTH];

    data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: ReadData=%0d expected=%0d (addr=%0d rd=%0b wr=%0b rst=%0b)",
                     tag, got, exp, Address, MemRead, MemWrite, rst);
        end
    endtask

    // Expected value on the read port for the inputs currently applied.
    function automatic int model_read();
        if (MemRead !== 1'b1) return 0;
`ifdef DATA_MEMORY_FWD_EN
        if (MemWrite === 1'b1 && rst === 1'b1) return int'(WriteData);
`endif
        return ref_mem[Address];
    endfunction

    // Model of one rising clk edge.
    task automatic model_edge();
        if (rst === 1'b0) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        end else if (MemWrite === 1'b1) begin
            ref_mem[Address] = int'(WriteData);
        end
    endtask

    // Drive the inputs mid-cycle. Optionally check the combinational read
    // (exp < 0 means use the model), then take one clock edge.
    task automatic step(input logic r, input logic rd, input logic wr,
                        input int addr, input int wdata,
                        input bit do_chk, input string tag, input int exp);
        @(negedge clk);
        rst = r; MemRead = rd; MemWrite = wr;
        Address = addr[AW-1:0]; WriteData = wdata[DW-1:0];
        #1;
        if (do_chk) chk(tag, int'(ReadData), (exp < 0) ? model_read() : exp);
        @(posedge clk);
        model_edge();
    endtask

    // Read without clocking any write: set the address and check the port.
    task automatic peek(input logic rd, input int addr, input string tag, input int exp);
        @(negedge clk);
        rst = 1'b1; MemRead = rd; MemWrite = 1'b0; Address = addr[AW-1:0]; WriteData = '0;
        #1;
        chk(tag, int'(ReadData), exp);
    endtask

    initial begin
        int a, d;
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;

        // Reset, then read back across the address range.
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, "", 0);
        peek(1'b1, 20,  "rst_a20",  0);
        peek(1'b1, 0,   "rst_a0",   0);
        peek(1'b1, 255, "rst_a255", 0);

        // Basic write and read-back.
        step(1'b1, 1'b0, 1'b1, 120, 123, 1'b0, "", 0);
        peek(1'b1, 120, "wr_a120", 123);
        peek(1'b1, 0,   "wr_a0",   0);

        // Read gating.
        peek(1'b0, 120, "gate_off", 0);
        peek(1'b1, 120, "gate_on",  123);

        // Address-range boundaries.
        step(1'b1, 1'b0, 1'b1, 0,   8'hAA, 1'b0, "", 0);
        step(1'b1, 1'b0, 1'b1, 255, 8'h55, 1'b0, "", 0);
        peek(1'b1, 0,   "bnd_a0",   8'hAA);
        peek(1'b1, 255, "bnd_a255", 8'h55);
        peek(1'b1, 1,   "bnd_a1",   0);

        // Reset dominates a write in the same cycle.
        step(1'b0, 1'b0, 1'b1, 7, 9, 1'b0, "", 0);
        peek(1'b1, 7,   "rdom_a7",   0);
        peek(1'b1, 120, "rdom_a120", 0);
        peek(1'b1, 0,   "rdom_a0",   0);

        // Simultaneous read and write to the same address.
        step(1'b1, 1'b0, 1'b1, 5, 3, 1'b0, "", 0);
`ifdef DATA_MEMORY_FWD_EN
        step(1'b1, 1'b1, 1'b1, 5, 4, 1'b1, "rw_pre", 4);
`else
        step(1'b1, 1'b1, 1'b1, 5, 4, 1'b1, "rw_pre", 3);
`endif
        peek(1'b1, 5, "rw_post", 4);

        // Randomized traffic. Addresses are often drawn from a small pool so
        // that reads hit addresses that have been written.
        for (int n = 0; n < 1500; n++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7) * 36;
            d = $urandom_range(0, 255);
            step(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1,
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 a, d, 1'b1, "rand", -1);
        end

        // Sweep every address against the model.
        for (int i = 0; i < DEPTH; i++) begin
            peek(1'b1, i, "sweep", ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter ADDR_WIDTH, default 8: address width; depth is 2^ADDR_WIDTH words.
REQ-003 Parameter DATA_WIDTH, default 8: word width in bits.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-low reset; 0 sampled at a rising clk edge resets the block.
REQ-006 Address  input  ADDR_WIDTH  word address for both read and write.
REQ-007 WriteData  input  DATA_WIDTH  data to store.
REQ-008 MemRead  input  1  read enable, active high.
REQ-009 MemWrite  input  1  write enable, active high.
REQ-010 ReadData  output  DATA_WIDTH  read result.

Function
REQ-011 Storage SHALL be 2^ADDR_WIDTH words of DATA_WIDTH bits, word-addressed; address 0 to 2^ADDR_WIDTH-1 all valid, no wrap or aliasing.
REQ-012 Write: at a rising clk edge with rst=1 and MemWrite=1, mem[Address] SHALL take WriteData; visible from the next cycle.
REQ-013 MemWrite=0 SHALL leave memory unchanged.
REQ-014 Read SHALL be combinational, with zero latency: ReadData = mem[Address] while MemRead=1.
REQ-015 MemRead=0 SHALL force ReadData to all zeros.
REQ-016 ReadData SHALL update in the same cycle when Address changes while MemRead=1.
REQ-017 MemRead=1 and MemWrite=1 together, same address: ReadData SHALL show the pre-write content until the edge, then the new value. The exception is forwarding under REQ-024.
REQ-018 X or unknown on MemWrite is out of scope; the implementation SHALL treat only 1 as write.
REQ-019 No handshake, busy or error outputs; every access completes in one cycle.

Reset
REQ-020 A rising clk edge with rst=0 SHALL clear every memory word to 0 in that single edge.
REQ-021 Reset SHALL dominate: a write requested in a reset cycle SHALL be discarded.
REQ-022 During and after reset, ReadData SHALL be 0 for any address with MemRead=1 until a write occurs.
REQ-023 Reset asserted mid-operation, between writes, SHALL lose all prior contents; no partial state survives.

Configuration
REQ-024 Macro DATA_MEMORY_FWD_EN:
- Defined: when MemRead=1, MemWrite=1 and rst=1, ReadData SHALL equal WriteData combinationally, i.e. write-through forwarding.
- Undefined: REQ-017 applies unmodified.
- All other behaviour is identical in both builds.

Verification
REQ-025 Reset: rst=0 for one edge, then rst=1, MemRead=1, Address=20, then 0, then 255 -> ReadData=0 at each address.
REQ-026 Write/read: Address=120, MemWrite=1, WriteData=123, one edge -> MemWrite=0, MemRead=1, Address=120 gives ReadData=123; Address=0 gives ReadData=0.
REQ-027 Read gating: after the write of REQ-026, MemRead=0, Address=120 -> ReadData=0; MemRead=1 -> ReadData=123 in the same cycle.
REQ-028 Boundaries: write 0xAA at address 0 and 0x55 at address 255 -> read back 0xAA and 0x55 with no cross-corruption; address 1 reads 0.
REQ-029 Reset dominance: rst=0 with MemWrite=1, Address=7, WriteData=9 on an edge -> afterwards address 7 reads 0; a prior write to address 120 also reads 0.
REQ-030 Simultaneous read/write: address 5 holds 3; MemRead=1, MemWrite=1, WriteData=4 -> before the edge ReadData=3 without DATA_MEMORY_FWD_EN and 4 with it; after the edge 4 in both builds.
